// File: rtl/vga_timing_pkg.sv
// Shared raster geometry for the video pipeline: default 800x600@60 timing,
// counter width and helpers deriving totals and sync windows.
package vga_timing_pkg;

    localparam int CNT_W   = 11;
    localparam int CNT_MAX = 2 ** CNT_W;

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FP      = 40;
    localparam int DEF_H_SYNC    = 128;
    localparam int DEF_H_BP      = 88;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FP      = 1;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BP      = 23;

    function automatic int span_total(int vis, int fp, int sync, int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int sync_start(int vis, int fp);
        return vis + fp;
    endfunction

    function automatic int sync_end(int vis, int fp, int sync);
        return vis + fp + sync;
    endfunction

endpackage

// File: rtl/vga_timing_gen_counter.sv
// Modulo counter: advances on inc, wraps to 0 after MODULUS-1 and flags the
// wrap combinationally so a following counter can chain off it.
module mod_counter
    import vga_timing_pkg::*;
#(
    parameter int MODULUS = 1056,
    parameter int INIT    = 0,
    parameter int W       = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        wrap    = inc && (count_q == W'(MODULUS - 1));
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= W'(INIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing source: position, sync and blanking stream
// for the overlay stages, all outputs registered and mutually aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit SYNC_POL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic             frame_start
);

    localparam int H_TOTAL = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int CW1     = CNT_W + 1;

    localparam logic [CW1-1:0] H_VIS_END = CW1'(H_VISIBLE);
    localparam logic [CW1-1:0] H_SYNC_S  = CW1'(sync_start(H_VISIBLE, H_FP));
    localparam logic [CW1-1:0] H_SYNC_E  = CW1'(sync_end(H_VISIBLE, H_FP, H_SYNC));
    localparam logic [CW1-1:0] V_VIS_END = CW1'(V_VISIBLE);
    localparam logic [CW1-1:0] V_SYNC_S  = CW1'(sync_start(V_VISIBLE, V_FP));
    localparam logic [CW1-1:0] V_SYNC_E  = CW1'(sync_end(V_VISIBLE, V_FP, V_SYNC));

    generate
        if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_geom_chk
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
        end
    endgenerate

    // Counters run one position ahead so the decoded flags can be registered
    // alongside the counts they describe.
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    mod_counter #(.MODULUS(H_TOTAL), .INIT(1), .W(CNT_W)) u_hcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    mod_counter #(.MODULUS(V_TOTAL), .INIT(0), .W(CNT_W)) u_vcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    logic [CNT_W-1:0] hcount_d, hcount_q;
    logic [CNT_W-1:0] vcount_d, vcount_q;
    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;
    logic             hblnk_d, hblnk_q;
    logic             vblnk_d, vblnk_q;
    logic             fstart_d, fstart_q;
    logic             fwrap_d, fwrap_q;
    logic             hs_act, vs_act;
    logic [CW1-1:0]   h_ext, v_ext;

    always_comb begin
        h_ext    = {1'b0, h_cnt};
        v_ext    = {1'b0, v_cnt};
        hs_act   = (h_ext >= H_SYNC_S) && (h_ext < H_SYNC_E);
        vs_act   = (v_ext >= V_SYNC_S) && (v_ext < V_SYNC_E);
        hcount_d = h_cnt;
        vcount_d = v_cnt;
        hsync_d  = SYNC_POL ? hs_act : !hs_act;
        vsync_d  = SYNC_POL ? vs_act : !vs_act;
        hblnk_d  = h_ext >= H_VIS_END;
        vblnk_d  = v_ext >= V_VIS_END;
        fwrap_d  = v_wrap;
        // Set only when the counters reached (0,0) through a frame wrap.
        fstart_d = fwrap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= !SYNC_POL;
            vsync_q  <= !SYNC_POL;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            fstart_q <= 1'b0;
            fwrap_q  <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            fstart_q <= fstart_d;
            fwrap_q  <= fwrap_d;
        end
    end

    assign hcount_out  = hcount_q;
    assign vcount_out  = vcount_q;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign hblnk_out   = hblnk_q;
    assign vblnk_out   = vblnk_q;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry plus a small geometry at both
// sync polarities, checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
    } vid_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   t = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Clocks elapsed since reset release: the model's only state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    logic [10:0] hc_def, vc_def, hc_s1, vc_s1, hc_s0, vc_s0;
    logic hs_def, vs_def, hb_def, vb_def, fs_def;
    logic hs_s1, vs_s1, hb_s1, vb_s1, fs_s1;
    logic hs_s0, vs_s0, hb_s0, vb_s0, fs_s0;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n),
        .hcount_out(hc_def), .vcount_out(vc_def),
        .hsync_out(hs_def), .vsync_out(vs_def),
        .hblnk_out(hb_def), .vblnk_out(vb_def),
        .frame_start(fs_def)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .hcount_out(hc_s1), .vcount_out(vc_s1),
        .hsync_out(hs_s1), .vsync_out(vs_s1),
        .hblnk_out(hb_s1), .vblnk_out(vb_s1),
        .frame_start(fs_s1)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) u_s0 (
        .clk(clk), .rst_n(rst_n),
        .hcount_out(hc_s0), .vcount_out(vc_s0),
        .hsync_out(hs_s0), .vsync_out(vs_s0),
        .hblnk_out(hb_s0), .vblnk_out(vb_s0),
        .frame_start(fs_s0)
    );

    vid_t a_def, a_s1, a_s0;
    assign a_def = {hc_def, vc_def, hs_def, vs_def, hb_def, vb_def, fs_def};
    assign a_s1  = {hc_s1, vc_s1, hs_s1, vs_s1, hb_s1, vb_s1, fs_s1};
    assign a_s0  = {hc_s0, vc_s0, hs_s0, vs_s0, hb_s0, vb_s0, fs_s0};

    function automatic vid_t model(int hv, int hf, int hsw, int hbp,
                                   int vv, int vf, int vsw, int vbp,
                                   bit pol, int tt);
        vid_t m;
        int ht = hv + hf + hsw + hbp;
        int vt = vv + vf + vsw + vbp;
        int h = tt % ht;
        int v = (tt / ht) % vt;
        bit hact = (h >= hv + hf) && (h < hv + hf + hsw);
        bit vact = (v >= vv + vf) && (v < vv + vf + vsw);
        m.h  = 11'(h);
        m.v  = 11'(v);
        m.hs = pol ? hact : !hact;
        m.vs = pol ? vact : !vact;
        m.hb = h >= hv;
        m.vb = v >= vv;
        m.fs = (tt > 0) && (tt % (ht * vt) == 0);
        return m;
    endfunction

    task automatic check(string nm, vid_t got, vid_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s t=%0d got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b required h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
                         nm, t, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.fs,
                         exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.fs);
        end
    endtask

    task automatic lit(string nm, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got %0d required %0d", nm, t, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("def", a_def, model(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, t));
        check("s1", a_s1, model(16, 2, 4, 3, 8, 1, 2, 3, 1'b1, t));
        check("s0", a_s0, model(16, 2, 4, 3, 8, 1, 2, 3, 1'b0, t));
    end

    int   last_fs = -1;
    int   last_hr = -1;
    logic hs_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_fs = -1;
            last_hr = -1;
        end else begin
            if (fs_s1) begin
                if (last_fs >= 0) lit("fs_period", t - last_fs, 350);
                last_fs = t;
            end
            if (hs_s1 && !hs_prev) begin
                if (last_hr >= 0) lit("hs_period", t - last_hr, 25);
                last_hr = t;
            end
        end
        hs_prev = hs_s1;
    end

    task automatic wait_t(int n);
        while (t < n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        lit("rst_hc", int'(hc_def), 0);
        lit("rst_hs_pol1", int'(hs_s1), 0);
        lit("rst_hs_pol0", int'(hs_s0), 1);
        lit("rst_vs_pol0", int'(vs_s0), 1);
        lit("rst_fs", int'(fs_def), 0);
        #2 rst_n = 1'b1;

        wait_t(1);
        lit("first_hc", int'(hc_def), 1);
        lit("first_vc", int'(vc_def), 0);
        lit("first_hb", int'(hb_def), 0);
        wait_t(15);
        lit("s1_hb_15", int'(hb_s1), 0);
        wait_t(16);
        lit("s1_hb_16", int'(hb_s1), 1);
        wait_t(18);
        lit("s1_hs_18", int'(hs_s1), 1);
        lit("s0_hs_18", int'(hs_s0), 0);
        wait_t(21);
        lit("s1_hs_21", int'(hs_s1), 1);
        wait_t(22);
        lit("s1_hs_22", int'(hs_s1), 0);
        lit("s0_hs_22", int'(hs_s0), 1);
        wait_t(25);
        lit("s1_hc_25", int'(hc_s1), 0);
        lit("s1_vc_25", int'(vc_s1), 1);
        wait_t(200);
        lit("s1_vb_200", int'(vb_s1), 1);
        wait_t(224);
        lit("s1_vs_224", int'(vs_s1), 0);
        wait_t(225);
        lit("s1_vs_225", int'(vs_s1), 1);
        lit("s0_vs_225", int'(vs_s0), 0);
        wait_t(274);
        lit("s1_vs_274", int'(vs_s1), 1);
        wait_t(275);
        lit("s1_vs_275", int'(vs_s1), 0);
        wait_t(349);
        lit("s1_fs_349", int'(fs_s1), 0);
        lit("s1_vc_349", int'(vc_s1), 13);
        wait_t(350);
        lit("s1_fs_350", int'(fs_s1), 1);
        lit("s1_hc_350", int'(hc_s1), 0);
        lit("s1_vc_350", int'(vc_s1), 0);
        wait_t(351);
        lit("s1_fs_351", int'(fs_s1), 0);
        wait_t(799);
        lit("def_hb_799", int'(hb_def), 0);
        wait_t(800);
        lit("def_hb_800", int'(hb_def), 1);
        wait_t(839);
        lit("def_hs_839", int'(hs_def), 0);
        wait_t(840);
        lit("def_hs_840", int'(hs_def), 1);
        wait_t(967);
        lit("def_hs_967", int'(hs_def), 1);
        wait_t(968);
        lit("def_hs_968", int'(hs_def), 0);
        wait_t(1055);
        lit("def_hc_1055", int'(hc_def), 1055);
        wait_t(1056);
        lit("def_hc_1056", int'(hc_def), 0);
        lit("def_vc_1056", int'(vc_def), 1);
        wait_t(1100);

        #2 rst_n = 1'b0;
        #1;
        lit("mid_hc_def", int'(hc_def), 0);
        lit("mid_vc_def", int'(vc_def), 0);
        lit("mid_hc_s1", int'(hc_s1), 0);
        lit("mid_vc_s1", int'(vc_s1), 0);
        lit("mid_hs_s0", int'(hs_s0), 1);
        lit("mid_hb_def", int'(hb_def), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        wait_t(1);
        lit("rel_hc_def", int'(hc_def), 1);
        lit("rel_vc_def", int'(vc_def), 0);
        lit("rel_hc_s1", int'(hc_s1), 1);
        wait_t(350);
        lit("rel_fs_s1", int'(fs_s1), 1);
        wait_t(360);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running raster timing source that produces the pixel-position and sync/blanking stream consumed by every overlay stage downstream (rectangle, background, sprite stages). It sits at the head of the video pipeline, one clock domain, and defines the frame geometry that all consumers interpret. Default geometry is 800x600 @ 60 Hz on a 40 MHz pixel clock.

## Interface
Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_VISIBLE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, sync active level (1 = active-high, 0 = active-low)

Ports:
- clk  in  1  pixel clock; one clock, all logic on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- hcount_out  out  11  horizontal pixel position, 0..H_TOTAL-1
- vcount_out  out  11  vertical line position, 0..V_TOTAL-1
- hsync_out  out  1  horizontal sync, level per SYNC_POL
- vsync_out  out  1  vertical sync, level per SYNC_POL
- hblnk_out  out  1  high outside visible columns
- vblnk_out  out  1  high outside visible lines
- frame_start  out  1  one-cycle pulse coincident with (0,0) after a wrap

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (628). Both must be ≤ 2048; elaboration error otherwise.
- Horizontal counter increments every clock; at H_TOTAL-1 wraps to 0 and vertical counter advances.
- Vertical counter at V_TOTAL-1 coincident with horizontal wrap → wraps to 0 (frame wrap).
- hblnk = hcount ≥ H_VISIBLE; vblnk = vcount ≥ V_VISIBLE.
- hsync asserted iff H_VISIBLE+H_FP ≤ hcount < H_VISIBLE+H_FP+H_SYNC (defaults 840..967).
- vsync asserted iff V_VISIBLE+V_FP ≤ vcount < V_VISIBLE+V_FP+V_SYNC (defaults 601..604), for full lines (hcount 0..H_TOTAL-1).
- SYNC_POL=0 inverts hsync_out/vsync_out only; blanking always active-high.
- frame_start = 1 only in the cycle whose outputs show (0,0) reached by frame wrap.
- No enable, no stall: counters never pause outside reset.

## Timing
- Reset (rst_n low, asynchronous): hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0, frame_start=0, hsync_out/vsync_out = inactive level (0 when SYNC_POL=1, 1 when SYNC_POL=0).
- Outputs are all registered and mutually aligned: every flag on a given cycle describes the hcount_out/vcount_out shown on that same cycle (flags decoded from next-state counts, zero relative skew).
- First rising edge after rst_n deasserts: hcount_out=1. First frame after reset produces no frame_start; first pulse at cycle H_TOTAL*V_TOTAL (663168) after release.
- Reset asserted mid-frame: outputs return to reset values immediately; counting restarts from (0,0) on release.
- Line period exactly H_TOTAL clocks, frame period exactly H_TOTAL*V_TOTAL clocks.

## Structure
- Package vga_timing_pkg: default geometry constants (800x600 set), counter width (11), derived H_TOTAL/V_TOTAL and sync start/end localparams helper.
- One sub-module natural: mod_counter (parameter MODULUS; inc in, count out, wrap out), instantiated twice, horizontal wrap feeding vertical inc.
- Decode/register stage lives in vga_timing_gen top.

## Test plan
- Reset then release: during reset all outputs at reset values; 1st edge after release → hcount_out=1, vcount_out=0, hblnk_out=0.
- Line boundary: at hcount 799→800 hblnk_out rises same cycle; hsync_out high for hcount 840..967 exactly (128 cycles); hcount 1055 → next cycle hcount 0, vcount+1.
- Frame boundary: vblnk_out high for vcount 600..627; vsync_out high for vcount 601..604 (4*1056 = 4224 cycles); after (1055,627) → (0,0) with frame_start=1 for exactly one cycle.
- Periodicity: two consecutive frame_start pulses exactly 663168 cycles apart; hsync rising edges exactly 1056 apart.
- SYNC_POL=0: hsync_out/vsync_out idle 1, low over same windows; blanking unchanged; reset drives syncs to 1.
- Async reset mid-frame at (412,317): outputs go to reset values without waiting for a clock edge; restart counts from (1,0) on first edge after release.
